m_axil_bridge: RTL and testbench

- AXI4-Lite master that converts the core's single-outstanding memory request (req/we/addr/wdata) into AXI4-Lite read or write transactions.
- Sits directly upstream of the peripheral AXI4-Lite slave, which holds the data0/data1 registers at offsets 0x0/0x4.
- One transaction in flight at a time.
- Returns a one-cycle ack with read data and an error flag.
- A bounded-wait counter stops a hung slave from stalling the core forever.

---
 rtl/m_axil_bridge_pkg.sv | 26 ++
 rtl/axil_timeout_cnt.sv | 33 +++
 rtl/m_axil_bridge.sv | 191 +++++++++++++++++++
 tb/tb_m_axil_bridge.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_axil_bridge_pkg.sv
// Shared types and constants for the core-to-AXI4-Lite master bridge
// and the peripheral slave behind it.
package m_axil_bridge_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 28;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// Bounded-wait counter: fires on the cycle the count of enabled cycles
// reaches LIMIT. LIMIT = 0 disables it.
module axil_timeout_cnt #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    // Expires on the edge that would complete the LIMIT-th enabled cycle.
    assign expired = (LIMIT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/m_axil_bridge.sv
// AXI4-Lite master: turns the core's single-outstanding req/we/addr/wdata
// request into one AXI4-Lite read or write and returns a one-cycle ack.
module m_axil_bridge
    import m_axil_bridge_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = DATA_WIDTH,
    parameter int C_M_AXI_ADDR_WIDTH = ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            req,
    output logic                            req_ready,
    input  logic                            we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                            ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rdata,
    output logic                            err,
    output logic                            timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    state_e                            state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q;
    logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic ack_q, err_q, timeout_q;

    logic aw_left, w_left, done, expired, abort;

    // A channel is still owed a handshake while its VALID is up and unmatched.
    assign aw_left = awvalid_q && !M_AXI_AWREADY;
    assign w_left  = wvalid_q  && !M_AXI_WREADY;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        done = 1'b0;
        case (state)
            ST_WR:   done = !aw_left && !w_left;
            ST_WB:   done = M_AXI_BVALID;
            ST_RA:   done = M_AXI_ARREADY;
            ST_RD:   done = M_AXI_RVALID;
            default: done = 1'b0;
        endcase
    end

    axil_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .enable  (state != ST_IDLE),
        .clear   (state == ST_IDLE),
        .expired (expired)
    );

    // A handshake landing on the expiry cycle completes normally.
    assign abort = expired && !done;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            if (abort) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                ack_q     <= 1'b1;
                err_q     <= 1'b1;
                timeout_q <= 1'b1;
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req) begin
                            addr_q  <= addr;
                            wdata_q <= wdata;
                            wstrb_q <= wstrb;
                            if (we) begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state     <= ST_WR;
                            end else begin
                                arvalid_q <= 1'b1;
                                state     <= ST_RA;
                            end
                        end
                    end
                    ST_WR: begin
                        awvalid_q <= aw_left;
                        wvalid_q  <= w_left;
                        if (done) begin
                            bready_q <= 1'b1;
                            state    <= ST_WB;
                        end
                    end
                    ST_WB: begin
                        if (done) begin
                            bready_q <= 1'b0;
                            ack_q    <= 1'b1;
                            err_q    <= resp_is_err(M_AXI_BRESP);
                            state    <= ST_IDLE;
                        end
                    end
                    ST_RA: begin
                        if (done) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state     <= ST_RD;
                        end
                    end
                    ST_RD: begin
                        if (done) begin
                            rready_q <= 1'b0;
                            rdata_q  <= M_AXI_RDATA;
                            err_q    <= resp_is_err(M_AXI_RRESP);
                            ack_q    <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign req_ready     = (state == ST_IDLE);
    assign ack           = ack_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign timeout       = timeout_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = AXI_PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = AXI_PROT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_m_axil_bridge.sv
// Bench for m_axil_bridge: a two-register AXI4-Lite slave with tunable
// stalls, a transaction-level model of the bridge, and directed scenarios.
module tb_m_axil_bridge;
    import m_axil_bridge_pkg::*;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          req_ready, ack, err, timeout;
    logic [DW-1:0] rdata;

    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata_o;
    logic [SW-1:0] wstrb_o;
    logic          m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]    m_bresp, m_rresp;
    logic [DW-1:0] m_rdata;

    m_axil_bridge #(
        .C_M_AXI_DATA_WIDTH (DW),
        .C_M_AXI_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .req           (req),
        .req_ready     (req_ready),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .ack           (ack),
        .rdata         (rdata),
        .err           (err),
        .timeout       (timeout),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (m_awready),
        .M_AXI_WDATA   (wdata_o),
        .M_AXI_WSTRB   (wstrb_o),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (m_wready),
        .M_AXI_BRESP   (m_bresp),
        .M_AXI_BVALID  (m_bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (m_arready),
        .M_AXI_RDATA   (m_rdata),
        .M_AXI_RRESP   (m_rresp),
        .M_AXI_RVALID  (m_rvalid),
        .M_AXI_RREADY  (rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave configuration (changed only while the bridge is idle).
    int         aw_wait = 0, w_wait = 0, b_wait = 0;
    bit         ar_hang = 1'b0;
    logic [1:0] bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;

    // Slave state: data0/data1 at offsets 0x0/0x4.
    logic [DW-1:0] smem [2];
    int            slave_writes = 0;

    // Slave: acts on handshakes completed at each rising edge, then drives
    // its outputs 1 time unit later.
    initial begin : slave
        bit            aw_got, w_got, b_arm;
        bit            aw_hs, w_hs, b_hs, ar_hs, r_hs;
        int            aw_seen, w_seen, b_cnt;
        logic [AW-1:0] aw_a;
        logic [DW-1:0] w_d;
        logic [SW-1:0] w_s;
        logic          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
        logic [AW-1:0] s_awaddr, s_araddr;
        logic [DW-1:0] s_wdata;
        logic [SW-1:0] s_wstrb;
        aw_got = 0; w_got = 0; b_arm = 0; aw_seen = 0; w_seen = 0; b_cnt = 0;
        aw_a = '0; w_d = '0; w_s = '0;
        s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        smem[0] = '0; smem[1] = '0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
        forever begin
            @(posedge clk);
            aw_hs = s_awvalid && m_awready;
            w_hs  = s_wvalid  && m_wready;
            b_hs  = m_bvalid  && s_bready;
            ar_hs = s_arvalid && m_arready;
            r_hs  = m_rvalid  && s_rready;
            #1;
            if (!rst_n) begin
                smem[0] = '0; smem[1] = '0;
                aw_got = 0; w_got = 0; b_arm = 0; aw_seen = 0; w_seen = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
            end else begin
                if (aw_hs) begin aw_got = 1; aw_a = s_awaddr; aw_seen = 0; end
                else if (s_awvalid) aw_seen++;
                if (w_hs) begin w_got = 1; w_d = s_wdata; w_s = s_wstrb; w_seen = 0; end
                else if (s_wvalid) w_seen++;
                if (b_hs) m_bvalid = 0;
                if (r_hs) m_rvalid = 0;
                if (aw_got && w_got) begin
                    for (int b = 0; b < SW; b++)
                        if (w_s[b]) smem[aw_a[2]][8*b +: 8] = w_d[8*b +: 8];
                    slave_writes++;
                    aw_got = 0; w_got = 0; b_arm = 1; b_cnt = b_wait;
                end
                if (b_arm) begin
                    if (b_cnt == 0) begin m_bvalid = 1; m_bresp = bresp_cfg; b_arm = 0; end
                    else b_cnt--;
                end
                if (ar_hs) begin m_rvalid = 1; m_rdata = smem[s_araddr[2]]; m_rresp = rresp_cfg; end
                s_awvalid = awvalid; s_wvalid = wvalid; s_bready = bready;
                s_arvalid = arvalid; s_rready = rready;
                s_awaddr = awaddr; s_araddr = araddr; s_wdata = wdata_o; s_wstrb = wstrb_o;
                m_awready = (aw_seen >= aw_wait);
                m_wready  = (w_seen >= w_wait);
                m_arready = !ar_hang;
            end
        end
    end

    // Transaction-level model of the bridge and the per-cycle compare.
    int            cyc = 0;
    bit            pend = 0, p_we = 0, p_err = 0, p_to = 0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0, p_rdata = '0, model_rdata = '0;
    logic [SW-1:0] p_strb = '0;
    int            p_deadline = 0;
    logic [DW-1:0] shadow [2];
    int            acc_cyc = 0, ack_cyc = 0, prev_ack_cyc = 0;
    bit            ack_err = 0, ack_to = 0;
    int            aw_hi = 0, w_hi = 0, ar_hi = 0;

    initial begin shadow[0] = '0; shadow[1] = '0; end

    always @(negedge clk) begin : compare
        bit exp_ack;
        int wait_wr;
        cyc++;
        if (!rst_n) begin
            check("reset_outputs", {awvalid, wvalid, bready, arvalid, rready, ack, err, timeout}, 0);
            check("reset_rdata", rdata, 0);
            pend = 0; shadow[0] = '0; shadow[1] = '0; model_rdata = '0;
        end else begin
            exp_ack = pend && (cyc == p_deadline);
            check("ack", ack, exp_ack);
            if (exp_ack) begin
                check("ack_err", err, p_err);
                check("ack_timeout", timeout, p_to);
                if (!p_we && !p_to) model_rdata = p_rdata;
                pend = 0;
                prev_ack_cyc = ack_cyc; ack_cyc = cyc; ack_err = err; ack_to = timeout;
            end
            check("rdata_held", rdata, model_rdata);
            check("req_ready", req_ready, !pend);
            check("prot", {awprot, arprot}, 0);
            if (awvalid) begin
                check("awaddr", {pend && p_we, awaddr}, {1'b1, p_addr});
                aw_hi++;
            end
            if (wvalid) begin
                check("w_payload", {pend && p_we, wdata_o, wstrb_o}, {1'b1, p_wdata, p_strb});
                w_hi++;
            end
            if (arvalid) begin
                check("araddr", {pend && !p_we, araddr}, {1'b1, p_addr});
                ar_hi++;
            end
            if (req && !pend) begin
                pend = 1; p_we = we; p_addr = addr; p_wdata = wdata; p_strb = wstrb;
                acc_cyc = cyc;
                if (we) begin
                    for (int b = 0; b < SW; b++)
                        if (wstrb[b]) shadow[addr[2]][8*b +: 8] = wdata[8*b +: 8];
                    wait_wr = (aw_wait > w_wait) ? aw_wait : w_wait;
                    p_deadline = cyc + 3 + wait_wr + b_wait;
                    p_err = bresp_cfg[1]; p_to = 0;
                end else if (ar_hang) begin
                    p_deadline = cyc + TO + 1;
                    p_err = 1; p_to = 1;
                end else begin
                    p_deadline = cyc + 3;
                    p_rdata = shadow[addr[2]];
                    p_err = rresp_cfg[1]; p_to = 0;
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        @(posedge clk); #2;
        req = 1; we = w; addr = a; wdata = d; wstrb = s;
        @(posedge clk); #2;
        req = 0; we = 0; addr = '0; wdata = '0; wstrb = '0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (!pend) break;
            @(posedge clk); #2;
        end
        check("wait_done", pend, 0);
    endtask

    initial begin : stimulus
        int w0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #2;
        check("idle_req_ready", req_ready, 1);

        // Zero-wait write to data0.
        aw_hi = 0; w_hi = 0;
        issue(1, 28'h0000000, 32'hDEADBEEF, 4'hF);
        wait_done();
        check("wr_latency", ack_cyc - acc_cyc, 3);
        check("wr_err", ack_err, 0);
        check("wr_data0", smem[0], 32'hDEADBEEF);
        check("wr_aw_cycles", aw_hi, 1);
        check("wr_w_cycles", w_hi, 1);

        // Write then read data1.
        issue(1, 28'h0000004, 32'h12345678, 4'hF);
        wait_done();
        ar_hi = 0;
        issue(0, 28'h0000004, '0, '0);
        wait_done();
        check("rd_latency", ack_cyc - acc_cyc, 3);
        check("rd_ar_cycles", ar_hi, 1);
        check("rd_data", rdata, 32'h12345678);
        check("rd_err", ack_err, 0);

        // AWREADY held low 3 cycles, partial strobes.
        aw_wait = 3; aw_hi = 0; w_hi = 0; w0 = slave_writes;
        issue(1, 28'h0000004, 32'hA5A50000, 4'hC);
        wait_done();
        aw_wait = 0;
        check("stall_aw_cycles", aw_hi, 4);
        check("stall_w_cycles", w_hi, 1);
        check("stall_one_write", slave_writes - w0, 1);
        check("stall_latency", ack_cyc - acc_cyc, 6);
        check("stall_data1", smem[1], 32'hA5A55678);

        // SLVERR on a read.
        rresp_cfg = RESP_SLVERR;
        issue(0, 28'h0000004, '0, '0);
        wait_done();
        rresp_cfg = RESP_OKAY;
        check("slverr_err", ack_err, 1);
        check("slverr_timeout", ack_to, 0);
        check("slverr_rdata", rdata, 32'hA5A55678);

        // Hung slave: ARREADY never rises.
        ar_hang = 1; ar_hi = 0;
        issue(0, 28'h0000000, '0, '0);
        wait_done();
        ar_hang = 0;
        check("to_ar_cycles", ar_hi, 8);
        check("to_latency", ack_cyc - acc_cyc, 9);
        check("to_err", ack_err, 1);
        check("to_timeout", ack_to, 1);
        check("to_rdata_kept", rdata, 32'hA5A55678);

        // Back-to-back: read accepted in the write's ack cycle.
        issue(1, 28'h0000000, 32'h0BADF00D, 4'hF);
        @(posedge clk);
        issue(0, 28'h0000000, '0, '0);
        wait_done();
        check("b2b_accept_on_ack", acc_cyc - prev_ack_cyc, 0);
        check("b2b_latency", ack_cyc - acc_cyc, 3);
        check("b2b_rdata", rdata, 32'h0BADF00D);

        // SLVERR on a write.
        bresp_cfg = RESP_SLVERR;
        issue(1, 28'h0000004, 32'h0000FFFF, 4'h1);
        wait_done();
        bresp_cfg = RESP_OKAY;
        check("wr_slverr_err", ack_err, 1);
        check("wr_slverr_data1", smem[1], 32'hA5A556FF);

        // Asynchronous reset while waiting in the write-response phase.
        b_wait = 3;
        issue(1, 28'h0000000, 32'hCAFE0001, 4'hF);
        for (int i = 0; i < 10; i++) begin
            if (bready) break;
            @(posedge clk); #2;
        end
        check("in_wb", bready, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_outputs", {awvalid, wvalid, bready, arvalid, rready, ack}, 0);
        check("async_rst_idle", req_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        b_wait = 0;
        issue(0, 28'h0000000, '0, '0);
        wait_done();
        check("post_rst_latency", ack_cyc - acc_cyc, 3);
        check("post_rst_rdata", rdata, 32'h0);
        check("post_rst_err", ack_err, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
